// File: rtl/led_pkg.sv
// led_pkg: definitions shared by the LED blinker and the fade/PWM brightness stage.
//   fade_state_t - 2-bit state of the fade controller
//   BLINK_CLK_HZ - blinker clock rate, shared with the blinker
//   PWM_BITS_DEF - default duty / PWM counter width
//   STEP_DIV_DEF - default clocks per one-LSB duty step (about 1 s full fade)
package led_pkg;

   localparam int BLINK_CLK_HZ = 50_000_000;
   localparam int PWM_BITS_DEF = 8;
   // One LSB step per 2^PWM_BITS-th of a second, so a 0->MAX fade lasts about 1 s.
   localparam int STEP_DIV_DEF = BLINK_CLK_HZ / (2 ** PWM_BITS_DEF);

   typedef enum logic [1:0] {
      OFF       = 2'd0,
      RAMP_UP   = 2'd1,
      ON        = 2'd2,
      RAMP_DOWN = 2'd3
   } fade_state_t;

endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: glitch-free PWM renderer.
//   blink_clk - clock, rising edge
//   sys_rst_n - asynchronous active-low reset
//   duty_in   - requested brightness, may change at any time
//   pwm_out   - registered PWM drive, high for duty_sh cycles of every 2^PWM_BITS
module pwm_gen
   import led_pkg::*;
#(
   parameter int PWM_BITS = PWM_BITS_DEF
) (
   input  logic                blink_clk,
   input  logic                sys_rst_n,
   input  logic [PWM_BITS-1:0] duty_in,
   output logic                pwm_out
);

   localparam logic [PWM_BITS-1:0] MAX = '1;

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] duty_sh;

   always_ff @(posedge blink_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pwm_cnt <= '0;
         duty_sh <= '0;
         pwm_out <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         // Shadow copy only reloads at the end of a period so no period is
         // ever cut short or stretched by a duty change.
         if (pwm_cnt == MAX)
            duty_sh <= duty_in;
         // MAX must be solid on; a plain compare would leave one low cycle.
         pwm_out <= (duty_sh == MAX) | (pwm_cnt < duty_sh);
      end
   end

endmodule

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: turns the blinker's on/off request into linear fades and
// drives the LED pin with PWM.
//   blink_clk - clock, rising edge (same domain as the blinker)
//   sys_rst_n - asynchronous active-low reset
//   led_req   - requested LED level from the blinker
//   pwm_led   - registered PWM drive to the LED pin
//   fade_busy - high while ramping up or down
//   duty      - current ramp brightness (not the PWM shadow copy)
module led_fade_pwm
   import led_pkg::*;
#(
   parameter int PWM_BITS = PWM_BITS_DEF,
   parameter int STEP_DIV = STEP_DIV_DEF
) (
   input  logic                blink_clk,
   input  logic                sys_rst_n,
   input  logic                led_req,
   output logic                pwm_led,
   output logic                fade_busy,
   output logic [PWM_BITS-1:0] duty
);

   localparam int                  CNT_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [PWM_BITS-1:0] MAX     = '1;
   localparam logic [CNT_W-1:0]    TICK_AT = CNT_W'(STEP_DIV - 1);

   fade_state_t      state;
   logic [CNT_W-1:0] step_cnt;
   logic             ramping;
   logic             step_tick;

   function automatic logic [PWM_BITS-1:0] sat_inc(input logic [PWM_BITS-1:0] d);
      return (d == MAX) ? MAX : d + 1'b1;
   endfunction

   function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] d);
      return (d == '0) ? '0 : d - 1'b1;
   endfunction

   assign ramping   = (state == RAMP_UP) || (state == RAMP_DOWN);
   assign step_tick = ramping && (step_cnt == TICK_AT);

   // A request change is checked before step_tick in every ramp state, so a
   // reversal landing on a tick swallows that tick's duty update and restarts
   // the step interval in the new direction.
   always_ff @(posedge blink_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= OFF;
         fade_busy <= 1'b0;
         duty      <= '0;
         step_cnt  <= '0;
      end else begin
         case (state)
            OFF: begin
               if (led_req) begin
                  state     <= RAMP_UP;
                  fade_busy <= 1'b1;
                  step_cnt  <= '0;
               end
            end
            ON: begin
               if (!led_req) begin
                  state     <= RAMP_DOWN;
                  fade_busy <= 1'b1;
                  step_cnt  <= '0;
               end
            end
            RAMP_UP: begin
               if (!led_req) begin
                  state    <= RAMP_DOWN;
                  step_cnt <= '0;
               end else if (step_tick) begin
                  step_cnt <= '0;
                  duty     <= sat_inc(duty);
                  if (sat_inc(duty) == MAX) begin
                     state     <= ON;
                     fade_busy <= 1'b0;
                  end
               end else begin
                  step_cnt <= step_cnt + 1'b1;
               end
            end
            RAMP_DOWN: begin
               if (led_req) begin
                  state    <= RAMP_UP;
                  step_cnt <= '0;
               end else if (step_tick) begin
                  step_cnt <= '0;
                  duty     <= sat_dec(duty);
                  if (sat_dec(duty) == '0) begin
                     state     <= OFF;
                     fade_busy <= 1'b0;
                  end
               end else begin
                  step_cnt <= step_cnt + 1'b1;
               end
            end
            default: begin
               state     <= OFF;
               fade_busy <= 1'b0;
               step_cnt  <= '0;
            end
         endcase
      end
   end

   pwm_gen #(
      .PWM_BITS (PWM_BITS)
   ) u_pwm (
      .blink_clk (blink_clk),
      .sys_rst_n (sys_rst_n),
      .duty_in   (duty),
      .pwm_out   (pwm_led)
   );

endmodule

// File: doc/led_fade_pwm.md
# led_fade_pwm

Brightness stage directly downstream of the LED blinker: consumes the blinker's on/off level and drives the physical LED pin. Each edge of the request becomes a linear fade, up or down, instead of a hard step. The brightness is rendered as a glitch-free PWM waveform. All logic runs in the blinker's clock domain, so no synchroniser is needed on the request input.

## Interface
- `PWM_BITS`, default 8: width of duty and PWM counter; `MAX = 2**PWM_BITS-1`.
- `STEP_DIV`, default 195312: clocks per one-LSB duty step; at 50 MHz and 8 bits a full fade takes about 1 s. Legal range is ≥1.
- `blink_clk`, in, 1: the only clock, rising edge.
- `sys_rst_n`, in, 1: asynchronous, active-low reset.
- `led_req`, in, 1: requested LED level from the blinker, synchronous to `blink_clk`.
- `pwm_led`, out, 1: registered PWM drive to the LED pin.
- `fade_busy`, out, 1: high while in `RAMP_UP` or `RAMP_DOWN`.
- `duty`, out, `PWM_BITS`: current target brightness; this is the ramp register, not the shadow copy.

## Operation
- **FSM states:** `OFF`, `RAMP_UP`, `ON`, `RAMP_DOWN`. Reset state is `OFF`.
- **Transitions:**
  - `OFF`: `led_req`=1 → `RAMP_UP`.
  - `ON`: `led_req`=0 → `RAMP_DOWN`.
  - `RAMP_UP`: `led_req`=0 → `RAMP_DOWN`, reversing from the current `duty`.
  - `RAMP_DOWN`: `led_req`=1 → `RAMP_UP`, reversing from the current `duty`.
  - `RAMP_UP` → `ON` on the step tick that makes `duty`=MAX.
  - `RAMP_DOWN` → `OFF` on the step tick that makes `duty`=0.
- **Step counter:**
  - Width is `$clog2(STEP_DIV)`, minimum 1.
  - Cleared to 0 on every state change.
  - Increments in ramp states only.
  - `step_tick` fires when count equals `STEP_DIV-1`; the counter then wraps to 0.
- **Duty update:** on `step_tick`, `duty` changes by ±1 according to the state.
  - `duty` never wraps; it saturates at 0 and MAX.
  - With `STEP_DIV`=1 a tick occurs every cycle in a ramp state.
- **Shadow duty and PWM counter:**
  - `pwm_cnt` is a free-running `PWM_BITS` counter that wraps MAX→0.
  - `duty_sh` loads from `duty` only in the cycle where `pwm_cnt`==MAX, so duty changes never occur mid-period.
- **Output compare:** `pwm_led` <= (`duty_sh`==MAX) | (`pwm_cnt` < `duty_sh`).
  - `duty_sh`=0 gives a constant 0; MAX gives a constant 1.
- **Simultaneous events:** if a request change and `step_tick` fall in the same cycle, the state change wins. That tick's duty update is suppressed and the counter is cleared.
- **Reset values:** all outputs and internal registers are 0.
  - `pwm_led`=0, `fade_busy`=0, `duty`=0, `duty_sh`=0, `pwm_cnt`=0, step counter=0, state=`OFF`.
- **Reset mid-fade:** reset takes effect immediately (asynchronous); after release the block restarts from `OFF` with the LED dark.

## Timing
- **Request to state:** a `led_req` change is sampled on edge N; the state and `fade_busy` update on that edge and are visible in cycle N+1.
- **First step:** the first `duty` step occurs `STEP_DIV` cycles after entering a ramp state.
- **Full-fade duration:** MAX×`STEP_DIV` cycles from entering `RAMP_UP` at `duty`=0 until `ON`.
- **`duty` to shadow:** a `duty` change is applied to `duty_sh` at the next `pwm_cnt`==MAX edge, which is up to 2^`PWM_BITS` cycles later.
- **Shadow to pin:** `duty_sh` reaches `pwm_led` with a 1-cycle register latency.
- **Duty meaning:** a PWM period is 2^`PWM_BITS` cycles, and `pwm_led` is high for `duty_sh` cycles per period (all cycles when `duty_sh`=MAX).

## Structure
- A shared `led_pkg` holds:
  - the FSM state enum `fade_state_t` (2-bit);
  - the default `PWM_BITS` and `STEP_DIV` constants, shared with the blinker's clock-rate constant.
- One natural sub-module, `pwm_gen`, contains:
  - `pwm_cnt`, `duty_sh` and the compare logic;
  - ports: `blink_clk`, `sys_rst_n`, `duty_in`, `pwm_out`.
- The top level contains the FSM, the step counter and the duty ramp.

## Test plan
All scenarios use `PWM_BITS`=4 (MAX=15) and `STEP_DIV`=3.
- **Reset:** assert `sys_rst_n`=0 mid-run → all outputs 0 immediately; after release, `pwm_led` stays 0 for ≥32 cycles with `led_req`=0.
- **Full ramp up:** raise `led_req` and hold → `fade_busy`=1 next cycle; `duty` increments every 3 cycles; `ON` is reached with `duty`=15 after 45 cycles, `fade_busy` drops, and `pwm_led` is constantly 1 once `duty_sh`=15.
- **PWM shape:** hold `duty` at 5 → `pwm_led` is high exactly 5 of every 16 cycles; `duty_sh` changes only at `pwm_cnt`=15.
- **Reversal:** drop `led_req` when `duty`=7 in `RAMP_UP` → next cycle state is `RAMP_DOWN`; `duty` reads 6 three cycles later, no overshoot, and it reaches 0/`OFF` after 21 cycles.
- **Collision:** toggle `led_req` on exactly the `step_tick` cycle → `duty` unchanged that cycle; the next step comes 3 cycles later, in the new direction.
- **Saturation:** hold `led_req`=1 for 200 cycles in `ON` → `duty` stays 15 and never wraps; hold 0 in `OFF` → `duty` stays 0.
